i2c_slave_core: RTL

I2C target front end for the register file. It recovers START, STOP and data bits from the oversampled bus and matches the 7-bit target address. It keeps the register pointer, which auto-increments per byte. Each received write byte is presented to the downstream register-update stage as a pointer/data pair with a one-cycle valid strobe. Read bytes come from the register file through a combinational read port indexed by the current pointer.

---
 rtl/i2c_slave_core.sv | 299 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_core.sv
// i2c_slave_core
//
// I2C target front end for the register file. It conditions the raw bus lines,
// recovers START/STOP/bit events, matches the 7-bit target address, keeps an
// auto-incrementing register pointer, hands each received write byte to the
// register-update stage, and serialises read bytes taken from a combinational
// register-file read port.
//
// Ports:
//   i_sys_clk    system clock, at least 20x the SCL frequency
//   i_rst        asynchronous active-high reset
//   i_scl        bus SCL (asynchronous)
//   i_sda        bus SDA input (asynchronous)
//   o_sda_oe     1 = pull SDA low, 0 = release
//   o_pointer    current register pointer
//   o_wr_data    last received write byte
//   o_wr_valid   one-cycle strobe, o_pointer/o_wr_data valid this cycle
//   i_rd_data    register contents at o_pointer
//   o_rd_strobe  one-cycle strobe when i_rd_data is captured for transmit
//   o_busy       high from a matched address ACK until STOP
module i2c_slave_core #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h50,
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic       i_sys_clk,
    input  logic       i_rst,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oe,
    output logic [7:0] o_pointer,
    output logic [7:0] o_wr_data,
    output logic       o_wr_valid,
    input  logic [7:0] i_rd_data,
    output logic       o_rd_strobe,
    output logic       o_busy
);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        WAIT_STOP
    } state_e;

    localparam logic [2:0] CNT_LAST = 3'(FILTER_LEN - 1);

    // Line index 0 carries SCL, index 1 carries SDA.
    logic [1:0]      sync1_q;
    logic [1:0]      sync2_q;
    logic [1:0]      filt_q;
    logic [1:0]      filtPrev_q;
    logic [1:0][2:0] cnt_q;

    state_e     state_q,    state_d;
    logic [2:0] bitCnt_q,   bitCnt_d;
    logic [7:0] shift_q,    shift_d;
    logic [7:0] pointer_q,  pointer_d;
    logic [7:0] wrData_q,   wrData_d;
    logic       wrValid_q,  wrValid_d;
    logic       rdStrobe_q, rdStrobe_d;
    logic       sdaOe_q,    sdaOe_d;
    logic       busy_q,     busy_d;
    logic       rw_q,       rw_d;
    logic       ackSeen_q,  ackSeen_d;

    logic sclRise;
    logic sclFall;
    logic sclHigh;
    logic startEv;
    logic stopEv;
    logic sdaIn;
    logic doLoad;

    // Two-flop synchronizer followed by a stability filter per line. A filtered
    // line only flips after FILTER_LEN consecutive synchronized samples that
    // disagree with it, so shorter glitches never reach the event logic.
    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1_q    <= 2'b11;
            sync2_q    <= 2'b11;
            filt_q     <= 2'b11;
            filtPrev_q <= 2'b11;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= {i_sda, i_scl};
            sync2_q    <= sync1_q;
            filtPrev_q <= filt_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    filt_q[i] <= sync2_q[i];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 3'd1;
                end
            end
        end
    end

    // Bus events come from comparing the filtered lines with their previous
    // value; SDA may only count as START/STOP while SCL is steadily high.
    always_comb begin
        sclRise = filt_q[0] & ~filtPrev_q[0];
        sclFall = ~filt_q[0] & filtPrev_q[0];
        sclHigh = filt_q[0] & filtPrev_q[0];
        startEv = sclHigh & filtPrev_q[1] & ~filt_q[1];
        stopEv  = sclHigh & ~filtPrev_q[1] & filt_q[1];
        sdaIn   = filt_q[1];
    end

    // Protocol state register; reset releases SDA immediately.
    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            bitCnt_q   <= '0;
            shift_q    <= '0;
            pointer_q  <= '0;
            wrData_q   <= '0;
            wrValid_q  <= 1'b0;
            rdStrobe_q <= 1'b0;
            sdaOe_q    <= 1'b0;
            busy_q     <= 1'b0;
            rw_q       <= 1'b0;
            ackSeen_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitCnt_q   <= bitCnt_d;
            shift_q    <= shift_d;
            pointer_q  <= pointer_d;
            wrData_q   <= wrData_d;
            wrValid_q  <= wrValid_d;
            rdStrobe_q <= rdStrobe_d;
            sdaOe_q    <= sdaOe_d;
            busy_q     <= busy_d;
            rw_q       <= rw_d;
            ackSeen_q  <= ackSeen_d;
        end
    end

    // Next-state logic. STOP and START override everything else. In the ACK
    // states o_sda_oe doubles as the phase marker: the first SCL fall starts
    // driving the ACK, the second one ends the slot.
    always_comb begin
        state_d    = state_q;
        bitCnt_d   = bitCnt_q;
        shift_d    = shift_q;
        pointer_d  = pointer_q;
        wrData_d   = wrData_q;
        wrValid_d  = 1'b0;
        rdStrobe_d = 1'b0;
        sdaOe_d    = sdaOe_q;
        busy_d     = busy_q;
        rw_d       = rw_q;
        ackSeen_d  = ackSeen_q;
        doLoad     = 1'b0;

        // The pointer advances the cycle after either strobe so the strobe
        // cycle still shows the address the byte belongs to.
        if (wrValid_q || rdStrobe_q) begin
            pointer_d = pointer_q + 8'd1;
        end

        if (stopEv) begin
            state_d = IDLE;
            sdaOe_d = 1'b0;
            busy_d  = 1'b0;
        end else if (startEv) begin
            state_d  = ADDR;
            bitCnt_d = '0;
            sdaOe_d  = 1'b0;
        end else begin
            case (state_q)
                ADDR: begin
                    if (sclRise) begin
                        shift_d  = {shift_q[6:0], sdaIn};
                        bitCnt_d = bitCnt_q + 3'd1;
                        if (bitCnt_q == 3'd7) begin
                            if (shift_q[6:0] == SLAVE_ADDR) begin
                                state_d = ADDR_ACK;
                                rw_d    = sdaIn;
                                busy_d  = 1'b1;
                            end else begin
                                state_d = WAIT_STOP;
                            end
                        end
                    end
                end
                ADDR_ACK: begin
                    if (sclFall) begin
                        if (!sdaOe_q) begin
                            sdaOe_d = 1'b1;
                        end else if (rw_q) begin
                            doLoad = 1'b1;
                        end else begin
                            sdaOe_d  = 1'b0;
                            state_d  = PTR;
                            bitCnt_d = '0;
                        end
                    end
                end
                PTR: begin
                    if (sclRise) begin
                        shift_d  = {shift_q[6:0], sdaIn};
                        bitCnt_d = bitCnt_q + 3'd1;
                        if (bitCnt_q == 3'd7) begin
                            pointer_d = {shift_q[6:0], sdaIn};
                            state_d   = PTR_ACK;
                        end
                    end
                end
                PTR_ACK: begin
                    if (sclFall) begin
                        if (!sdaOe_q) begin
                            sdaOe_d = 1'b1;
                        end else begin
                            sdaOe_d  = 1'b0;
                            state_d  = WR_DATA;
                            bitCnt_d = '0;
                        end
                    end
                end
                WR_DATA: begin
                    if (sclRise) begin
                        shift_d  = {shift_q[6:0], sdaIn};
                        bitCnt_d = bitCnt_q + 3'd1;
                        if (bitCnt_q == 3'd7) begin
                            state_d = WR_ACK;
                        end
                    end
                end
                WR_ACK: begin
                    // The byte is only committed once the ACK slot begins, so
                    // a STOP right after the 8th bit discards it.
                    if (sclFall) begin
                        if (!sdaOe_q) begin
                            sdaOe_d   = 1'b1;
                            wrData_d  = shift_q;
                            wrValid_d = 1'b1;
                        end else begin
                            sdaOe_d  = 1'b0;
                            state_d  = WR_DATA;
                            bitCnt_d = '0;
                        end
                    end
                end
                RD_DATA: begin
                    if (sclFall) begin
                        if (bitCnt_q == 3'd7) begin
                            sdaOe_d   = 1'b0;
                            state_d   = RD_ACK;
                            ackSeen_d = 1'b0;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sdaOe_d  = ~shift_q[6];
                            bitCnt_d = bitCnt_q + 3'd1;
                        end
                    end
                end
                RD_ACK: begin
                    if (sclRise) begin
                        if (sdaIn) begin
                            state_d = WAIT_STOP;
                        end else begin
                            ackSeen_d = 1'b1;
                        end
                    end else if (sclFall && ackSeen_q) begin
                        doLoad = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end

        // Start of a read byte: capture the register and drive its MSB.
        if (doLoad) begin
            shift_d    = i_rd_data;
            rdStrobe_d = 1'b1;
            sdaOe_d    = ~i_rd_data[7];
            bitCnt_d   = '0;
            state_d    = RD_DATA;
        end
    end

    assign o_sda_oe    = sdaOe_q;
    assign o_pointer   = pointer_q;
    assign o_wr_data   = wrData_q;
    assign o_wr_valid  = wrValid_q;
    assign o_rd_strobe = rdStrobe_q;
    assign o_busy      = busy_q;

endmodule
